corr_accum_dump: RTL

- Consumes the signed correlation products from the channelizer's DSP48 correlation multiplier (48-bit P port).
- Integrates them over a fixed window of CORR_LEN accepted products with a saturating accumulator.
- Emits one dump per window on an AXI-stream master, carrying the window sum, a threshold-exceed flag and a window index.
- Sits between the correlation multiplier output and the detection/control logic of the M2 channelizer.

---
 rtl/corr_accum_dump.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/corr_accum_dump.sv
// corr_accum_dump: windowed saturating integrator for correlation products.
// Sums CORR_LEN signed products per window and dumps sum/flag/index on AXIS.
//
// Ports:
//   clk, sync_reset              clock, synchronous active-high reset
//   s_axis_tvalid/tdata/tready   48-bit product input (low IN_WIDTH bits used)
//   threshold                    unsigned |sum| threshold, sampled at window close
//   m_axis_tvalid/tready         dump handshake
//   m_axis_tdata                 signed saturated window sum
//   m_axis_tuser                 |sum| >= threshold
//   m_axis_tindex                window number, wraps modulo 2^IDX_WIDTH
module corr_accum_dump #(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 32,
    parameter int CORR_LEN  = 64,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 s_axis_tvalid,
    input  logic [47:0]          s_axis_tdata,
    output logic                 s_axis_tready,
    input  logic [ACC_WIDTH-2:0] threshold,
    output logic                 m_axis_tvalid,
    output logic [ACC_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tuser,
    output logic [IDX_WIDTH-1:0] m_axis_tindex,
    input  logic                 m_axis_tready
);

    localparam int CNT_W = $clog2(CORR_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CORR_LEN - 1);
    localparam int SUM_W =
        ((IN_WIDTH > ACC_WIDTH) ? IN_WIDTH : ACC_WIDTH) + 1;

    localparam logic signed [SUM_W-1:0] MAX_S =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_S =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]        win_q, win_d;
    logic                        dvld_q, dvld_d;
    logic [ACC_WIDTH-1:0]        ddata_q, ddata_d;
    logic                        duser_q, duser_d;
    logic [IDX_WIDTH-1:0]        didx_q, didx_d;

    logic signed [IN_WIDTH-1:0]  x_in;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [SUM_W-1:0]     sum_w;
    logic signed [ACC_WIDTH-1:0] sat;
    logic [ACC_WIDTH-1:0]        mag;
    logic                        above;
    logic                        accept;
    logic                        close;
    logic                        unused_hi;

    assign unused_hi = ^s_axis_tdata[47:IN_WIDTH];
    assign x_in = s_axis_tdata[IN_WIDTH-1:0];

    // The first product of a window replaces the running sum.
    assign base  = (cnt_q == '0) ? '0 : acc_q;
    assign sum_w = SUM_W'(base) + SUM_W'(x_in);

    always_comb begin
        sat = sum_w[ACC_WIDTH-1:0];
        if (sum_w > MAX_S) begin
            sat = MAX_S[ACC_WIDTH-1:0];
        end else if (sum_w < MIN_S) begin
            sat = MIN_S[ACC_WIDTH-1:0];
        end
    end

    // Unsigned negate: the most-negative value maps to 2^(ACC_WIDTH-1).
    assign mag   = sat[ACC_WIDTH-1] ? (~sat + ACC_WIDTH'(1)) : sat;
    assign above = (mag >= {1'b0, threshold});

    // Only the window-closing product needs the dump register, so
    // mid-window products keep flowing while a dump is held.
    assign s_axis_tready = ~dvld_q | m_axis_tready | (cnt_q != LAST);

    assign accept = s_axis_tvalid & s_axis_tready;
    assign close  = accept & (cnt_q == LAST);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        dvld_d  = dvld_q;
        ddata_d = ddata_q;
        duser_d = duser_q;
        didx_d  = didx_q;

        if (dvld_q & m_axis_tready) begin
            dvld_d = 1'b0;
        end

        if (accept) begin
            acc_d = sat;
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A close on the handshake cycle overrides the clear above.
        if (close) begin
            cnt_d   = '0;
            win_d   = win_q + IDX_WIDTH'(1);
            dvld_d  = 1'b1;
            ddata_d = sat;
            duser_d = above;
            didx_d  = win_q;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            dvld_q  <= 1'b0;
            ddata_q <= '0;
            duser_q <= 1'b0;
            didx_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            dvld_q  <= dvld_d;
            ddata_q <= ddata_d;
            duser_q <= duser_d;
            didx_q  <= didx_d;
        end
    end

    assign m_axis_tvalid = dvld_q;
    assign m_axis_tdata  = ddata_q;
    assign m_axis_tuser  = duser_q;
    assign m_axis_tindex = didx_q;

endmodule
